// File: rtl/nios_led1_cpu_debug_pkg.sv
// Shared definitions for the CPU debug-slave virtual-JTAG link.
package nios_led1_cpu_debug_pkg;

    // Virtual IR codes understood by the debug slave
    localparam logic [1:0] IR_OCIMEM    = 2'b00;
    localparam logic [1:0] IR_TRACEMEM  = 2'b01;
    localparam logic [1:0] IR_BREAK     = 2'b10;
    localparam logic [1:0] IR_TRACECTRL = 2'b11;

    localparam int unsigned DEBUG_DR_W = 38;

    // Scan sequencer states; DONE is distinct from IDLE so accept and response never overlap
    typedef enum logic [2:0] {
        StIdle,
        StUir,
        StCdr,
        StSdr,
        StUdr,
        StRti,
        StDone
    } dbg_state_e;

endpackage

// File: rtl/nios_led1_cpu_cpu_debug_host_tckgen.sv
// Scan clock generator: divides clk into a 50% duty tck while run is high and
// flags the clk cycles in which tck rises or falls.
module nios_led1_cpu_cpu_debug_host_tckgen #(
    parameter int unsigned TCK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    output logic tck,
    output logic rise,
    output logic fall
);

    localparam int unsigned CW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TCK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic          cnt_wrap;

    assign cnt_wrap = run && (cnt_q == CNT_LAST);
    assign rise     = cnt_wrap && !tck;
    assign fall     = cnt_wrap && tck;

    // Half-period counter; tck toggles on each wrap and parks low when not running
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            tck   <= 1'b0;
        end else if (!run) begin
            cnt_q <= '0;
            tck   <= 1'b0;
        end else if (cnt_wrap) begin
            cnt_q <= '0;
            tck   <= ~tck;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/nios_led1_cpu_cpu_debug_host.sv
// Initiator of the CPU debug virtual-JTAG link: one IR+DR scan per command.
module nios_led1_cpu_cpu_debug_host
    import nios_led1_cpu_debug_pkg::*;
#(
    parameter int unsigned DR_W       = DEBUG_DR_W,
    parameter int unsigned IR_W       = 2,
    parameter int unsigned TCK_DIV    = 2,
    parameter int unsigned RTI_CYCLES = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [IR_W-1:0] cmd_ir,
    input  logic            cmd_skip_ir,
    input  logic [DR_W-1:0] cmd_dr,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DR_W-1:0] rsp_dr,
    output logic            busy,
    output logic            vji_tck,
    output logic            vji_tdi,
    input  logic            vji_tdo,
    output logic [IR_W-1:0] vji_ir_in,
    output logic            vji_uir,
    output logic            vji_cdr,
    output logic            vji_sdr,
    output logic            vji_udr,
    output logic            vji_rti
);

    localparam int unsigned BCW = $clog2(DR_W + 1);
    localparam int unsigned RCW = (RTI_CYCLES > 1) ? $clog2(RTI_CYCLES) : 1;
    localparam logic [BCW-1:0] BIT_LAST = BCW'(DR_W - 1);
    localparam logic [RCW-1:0] RTI_LAST = RCW'(RTI_CYCLES - 1);

    dbg_state_e      state_q;
    logic [DR_W-1:0] sh_q;
    logic [DR_W-1:0] sh_shift;
    logic [BCW-1:0]  bit_cnt_q;
    logic [RCW-1:0]  rti_cnt_q;
    logic            tdo_q;
    logic            run;
    logic            tck_rise;
    logic            tck_fall;

    // tck only runs through the scan phases; it stays low in IDLE and DONE
    assign run      = (state_q != StIdle) && (state_q != StDone);
    assign sh_shift = {tdo_q, sh_q[DR_W-1:1]};

    nios_led1_cpu_cpu_debug_host_tckgen #(
        .TCK_DIV (TCK_DIV)
    ) u_tckgen (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (run),
        .tck     (vji_tck),
        .rise    (tck_rise),
        .fall    (tck_fall)
    );

    // Scan sequencer: phases advance on tck fall events, tdo is sampled on rise events
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            sh_q      <= '0;
            bit_cnt_q <= '0;
            rti_cnt_q <= '0;
            tdo_q     <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_dr    <= '0;
            vji_tdi   <= 1'b0;
            vji_ir_in <= '0;
            vji_uir   <= 1'b0;
            vji_cdr   <= 1'b0;
            vji_sdr   <= 1'b0;
            vji_udr   <= 1'b0;
            vji_rti   <= 1'b0;
        end else begin
            if (tck_rise) begin
                tdo_q <= vji_tdo;
            end
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid && cmd_ready) begin
                        sh_q      <= cmd_dr;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (cmd_skip_ir) begin
                            state_q <= StCdr;
                            vji_cdr <= 1'b1;
                        end else begin
                            state_q   <= StUir;
                            vji_uir   <= 1'b1;
                            vji_ir_in <= cmd_ir;
                        end
                    end
                end
                StUir: begin
                    if (tck_fall) begin
                        state_q <= StCdr;
                        vji_uir <= 1'b0;
                        vji_cdr <= 1'b1;
                    end
                end
                StCdr: begin
                    if (tck_fall) begin
                        state_q <= StSdr;
                        vji_cdr <= 1'b0;
                        vji_sdr <= 1'b1;
                        vji_tdi <= sh_q[0];
                    end
                end
                StSdr: begin
                    if (tck_fall) begin
                        sh_q <= sh_shift;
                        if (bit_cnt_q == BIT_LAST) begin
                            bit_cnt_q <= '0;
                            state_q   <= StUdr;
                            vji_sdr   <= 1'b0;
                            vji_udr   <= 1'b1;
                            vji_tdi   <= 1'b0;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            vji_tdi   <= sh_shift[0];
                        end
                    end
                end
                StUdr: begin
                    if (tck_fall) begin
                        state_q   <= StRti;
                        rti_cnt_q <= '0;
                        vji_udr   <= 1'b0;
                        vji_rti   <= 1'b1;
                    end
                end
                StRti: begin
                    if (tck_fall) begin
                        if (rti_cnt_q == RTI_LAST) begin
                            state_q   <= StDone;
                            vji_rti   <= 1'b0;
                            rsp_valid <= 1'b1;
                            rsp_dr    <= sh_q;
                        end else begin
                            rti_cnt_q <= rti_cnt_q + 1'b1;
                        end
                    end
                end
                StDone: begin
                    if (rsp_ready) begin
                        state_q   <= StIdle;
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_nios_led1_cpu_cpu_debug_host.sv
// Directed bench for the debug host: scan vector table, DONE stall, mid-scan reset,
// plus a continuous monitor of tck shape, strobe exclusivity and rise-event quietness.
module tb_nios_led1_cpu_cpu_debug_host;
    import nios_led1_cpu_debug_pkg::*;

    localparam int unsigned DR_W       = 38;
    localparam int unsigned IR_W       = 2;
    localparam int unsigned TCK_DIV    = 2;
    localparam int unsigned RTI_CYCLES = 1;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [IR_W-1:0] cmd_ir = '0;
    logic            cmd_skip_ir = 1'b0;
    logic [DR_W-1:0] cmd_dr = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [DR_W-1:0] rsp_dr;
    logic            busy;
    logic            vji_tck, vji_tdi, vji_tdo;
    logic [IR_W-1:0] vji_ir_in;
    logic            vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

    int n_tests = 0;
    int n_fail  = 0;

    nios_led1_cpu_cpu_debug_host #(
        .DR_W       (DR_W),
        .IR_W       (IR_W),
        .TCK_DIV    (TCK_DIV),
        .RTI_CYCLES (RTI_CYCLES)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_ir      (cmd_ir),
        .cmd_skip_ir (cmd_skip_ir),
        .cmd_dr      (cmd_dr),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_dr      (rsp_dr),
        .busy        (busy),
        .vji_tck     (vji_tck),
        .vji_tdi     (vji_tdi),
        .vji_tdo     (vji_tdo),
        .vji_ir_in   (vji_ir_in),
        .vji_uir     (vji_uir),
        .vji_cdr     (vji_cdr),
        .vji_sdr     (vji_sdr),
        .vji_udr     (vji_udr),
        .vji_rti     (vji_rti)
    );

    always #5 clk = ~clk;

    // Slave model: load on cdr, shift on sdr, capture on udr, all at tck rise
    logic [DR_W-1:0] cdr_val = '0;
    logic [DR_W-1:0] sr = '0;
    logic [DR_W-1:0] cap = '0;
    int              cap_cnt = 0;

    assign vji_tdo = sr[0];

    always @(posedge vji_tck) begin
        if (vji_cdr) sr <= cdr_val;
        else if (vji_sdr) sr <= {vji_tdi, sr[DR_W-1:1]};
        if (vji_udr) begin
            cap     <= sr;
            cap_cnt <= cap_cnt + 1;
        end
    end

    // Monitor: cycle stamps, uir observation and protocol rules
    int        cyc = 0;
    int        acc_cyc = 0;
    int        rise_cyc = 0;
    int        uir_cnt = 0;
    logic [1:0] uir_ir = '0;
    int        mon_err = 0;
    logic      rv_prev = 1'b0;
    logic      uir_prev = 1'b0;
    logic      tck_prev = 1'b0;
    logic [7:0] vji_prev = '0;
    int        hi_cnt = 0;
    int        low_cnt = 0;

    always @(posedge clk) begin : mon
        logic [4:0] stb;
        logic [7:0] vji_now;
        int         e;
        e       = 0;
        stb     = {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti};
        vji_now = {vji_tdi, vji_ir_in, stb};
        cyc <= cyc + 1;
        if (cmd_valid && cmd_ready) acc_cyc <= cyc;
        if (rsp_valid && !rv_prev) rise_cyc <= cyc;
        if (vji_uir) uir_ir <= vji_ir_in;
        if (vji_uir && !uir_prev) uir_cnt <= uir_cnt + 1;
        rv_prev  <= rsp_valid;
        uir_prev <= vji_uir;
        if (!reset_n) begin
            tck_prev <= 1'b0;
            vji_prev <= vji_now;
            hi_cnt   <= 0;
            low_cnt  <= 0;
        end else begin
            if (vji_tck) begin
                if (!tck_prev) begin
                    if (vji_now != vji_prev) begin
                        $display("FAIL mon_rise_quiet: vji changed %h -> %h at rise", vji_prev, vji_now);
                        e++;
                    end
                    if (low_cnt != 2) begin
                        $display("FAIL mon_tck_low: low phase %0d clk, required 2", low_cnt);
                        e++;
                    end
                end
                hi_cnt  <= hi_cnt + 1;
                low_cnt <= 0;
            end else begin
                if (tck_prev && hi_cnt != 2) begin
                    $display("FAIL mon_tck_high: high phase %0d clk, required 2", hi_cnt);
                    e++;
                end
                hi_cnt  <= 0;
                low_cnt <= (stb != 0) ? low_cnt + 1 : 0;
            end
            if (busy && !rsp_valid && !$onehot(stb)) begin
                $display("FAIL mon_onehot: strobes %b while scanning", stb);
                e++;
            end
            if ((!busy || rsp_valid) && stb != 0) begin
                $display("FAIL mon_idle_strobes: strobes %b in IDLE/DONE", stb);
                e++;
            end
            tck_prev <= vji_tck;
            vji_prev <= vji_now;
        end
        mon_err <= mon_err + e;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, required 'h%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]      ir;
        logic            skip;
        logic [DR_W-1:0] dr;
        logic [DR_W-1:0] cdr;
        logic [1:0]      exp_ir;
        int              exp_lat;
        int              exp_uir;
    } vec_t;

    vec_t vecs[5];

    // One full command/response transaction with optional DONE stall
    task automatic run_scan(input vec_t v, input int stall, input string tag);
        int   uir0, cap0, stable;
        logic got;
        cdr_val = v.cdr;
        uir0    = uir_cnt;
        cap0    = cap_cnt;
        @(negedge clk);
        check({tag, "_ready"}, {63'd0, cmd_ready}, 64'd1);
        cmd_ir      = v.ir;
        cmd_skip_ir = v.skip;
        cmd_dr      = v.dr;
        cmd_valid   = 1'b1;
        @(negedge clk);
        // Keep requesting with different data: must be ignored while busy
        cmd_ir = ~v.ir;
        cmd_dr = ~v.dr;
        check({tag, "_busy"}, {62'd0, busy, cmd_ready}, 64'd2);
        got = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        check({tag, "_rsp_seen"}, {63'd0, got}, 64'd1);
        @(posedge clk);
        #1;
        check({tag, "_latency"}, 64'(rise_cyc - acc_cyc), 64'(v.exp_lat));
        check({tag, "_rsp_dr"}, 64'(rsp_dr), 64'(v.cdr));
        check({tag, "_cap_cnt"}, 64'(cap_cnt - cap0), 64'd1);
        check({tag, "_slave_cap"}, 64'(cap), 64'(v.dr));
        check({tag, "_uir_pulses"}, 64'(uir_cnt - uir0), 64'(v.exp_uir));
        check({tag, "_ir_in"}, 64'(vji_ir_in), 64'(v.exp_ir));
        if (v.exp_uir == 1) check({tag, "_ir_in_uir"}, 64'(uir_ir), 64'(v.exp_ir));
        stable = 0;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (rsp_valid && rsp_dr == v.cdr && !cmd_ready && !vji_tck && busy) stable++;
        end
        if (stall > 0) check({tag, "_stall_stable"}, 64'(stable), 64'(stall));
        @(negedge clk);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, "_back_idle"}, {61'd0, cmd_ready, rsp_valid, busy}, 64'd4);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, {60'd0, cmd_ready, rsp_valid, busy, vji_tck}, 64'h8);
        check({tag, "_vji"}, {56'd0, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti},
              64'd0);
        check({tag, "_rsp_dr"}, 64'(rsp_dr), 64'd0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int   seen;
        logic got;
        // Order matters: skip_ir rows expect the IR left by the previous row
        vecs[0] = '{IR_OCIMEM,    1'b0, 38'h2A_AAAA_AAAA, 38'h0F_0000_00F1, IR_OCIMEM,    169, 1};
        vecs[1] = '{IR_BREAK,     1'b0, 38'h15_5555_5555, 38'h3F_FFFF_FFFF, IR_BREAK,     169, 1};
        vecs[2] = '{IR_TRACEMEM,  1'b1, 38'h00_1234_5678, 38'h25_DEAD_BEEF, IR_BREAK,     165, 0};
        vecs[3] = '{IR_TRACECTRL, 1'b0, 38'h3F_FFFF_FFFF, 38'h00_0000_0000, IR_TRACECTRL, 169, 1};
        vecs[4] = '{IR_OCIMEM,    1'b1, 38'h01_0000_0001, 38'h20_0000_0000, IR_TRACECTRL, 165, 0};

        // Reset held for 5 cycles
        repeat (5) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", {63'd0, cmd_ready}, 64'd1);

        foreach (vecs[i]) run_scan(vecs[i], 0, $sformatf("vec%0d", i));

        // Response stalled in DONE
        run_scan(vecs[3], 20, "stall");

        // Reset asserted during SDR bit 17 of an IR_BREAK scan
        cdr_val = vecs[1].cdr;
        seen    = cap_cnt;
        @(negedge clk);
        cmd_ir      = vecs[1].ir;
        cmd_skip_ir = 1'b0;
        cmd_dr      = vecs[1].dr;
        cmd_valid   = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (vji_sdr) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("rst_sdr_seen", {63'd0, got}, 64'd1);
        repeat (17 * 4 + 1) @(negedge clk);
        check("rst_pre_state", {62'd0, vji_sdr, vji_ir_in == IR_BREAK}, 64'd3);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midscan_reset");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        got = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid) got = 1'b1;
        end
        check("rst_no_rsp", {63'd0, got}, 64'd0);
        check("rst_no_capture", 64'(cap_cnt - seen), 64'd0);

        run_scan(vecs[0], 0, "post_reset");

        repeat (4) @(negedge clk);
        check("monitor_violations", 64'(mon_err), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
